// File: rtl/dsi_crc_pkg.sv
// Shared CRC-16 constants, FSM state type and the bytewise reflected update.
// Latency: n/a (package, combinational helper only).
// Backpressure: n/a.
package dsi_crc_pkg;

    localparam logic [15:0] DSI_CRC_POLY_REFL = 16'h8408;
    localparam logic [15:0] DSI_CRC_INIT      = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } crc_state_t;

    // One payload byte folded into the running CRC, LSB of the byte first.
    function automatic logic [15:0] crc16_byte(
        input logic [15:0] crc_in,
        input logic [7:0]  data_byte,
        input logic [15:0] poly
    );
        logic [15:0] c;
        c = crc_in ^ {8'h00, data_byte};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ poly) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/dsi_crc_byte_lane.sv
// One byte lane of the CRC chain: folds data_byte into crc_in when enabled.
// Latency: combinational.
// Backpressure: none; a disabled lane passes crc_in straight through.
module dsi_crc_byte_lane
    import dsi_crc_pkg::*;
#(
    parameter logic [15:0] POLY = DSI_CRC_POLY_REFL
) (
    input  logic        en,
    input  logic [7:0]  data_byte,
    input  logic [15:0] crc_in,
    output logic [15:0] crc_out
);

    assign crc_out = en ? crc16_byte(crc_in, data_byte, POLY) : crc_in;

endmodule

// File: rtl/dsi_crc16_stream.sv
// Streaming DSI long-packet CRC-16 generator/checker over a multi-byte beat bus.
// Latency: crc_valid rises the cycle after the last beat is accepted.
// Backpressure: in_ready drops while a result waits for crc_ready; abort wins over everything.
module dsi_crc16_stream
    import dsi_crc_pkg::*;
#(
    parameter int          BYTES    = 4,
    parameter logic [15:0] CRC_INIT = DSI_CRC_INIT,
    parameter logic [15:0] CRC_POLY = DSI_CRC_POLY_REFL,
    parameter int          CNT_W    = 16
) (
    input  logic                       dsi_clk,
    input  logic                       dsi_rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [BYTES*8-1:0]         in_data,
    input  logic [$clog2(BYTES+1)-1:0] in_nbytes,
    input  logic                       in_last,
    input  logic                       abort,
    input  logic                       chk_en,
    input  logic [15:0]                rx_crc,
    output logic                       crc_valid,
    input  logic                       crc_ready,
    output logic [15:0]                crc,
    output logic                       crc_err,
    output logic [CNT_W-1:0]           byte_cnt
);

    localparam int NB_W = $clog2(BYTES + 1);
    localparam logic [NB_W-1:0] NB_MAX = NB_W'(BYTES);

    crc_state_t             state;
    logic [15:0]            crc_reg;
    logic [NB_W-1:0]        nb_eff;
    logic [BYTES:0][15:0]   lane_crc;
    logic [15:0]            crc_fold;
    logic [CNT_W:0]         cnt_sum;
    logic [CNT_W-1:0]       cnt_next;
    logic                   beat_acc;

    // Oversized byte counts are treated as a full beat.
    assign nb_eff = (in_nbytes > NB_MAX) ? NB_MAX : in_nbytes;

    // Lanes are chained in wire order; lanes at or beyond nb_eff are bypassed.
    assign lane_crc[0] = crc_reg;
    for (genvar k = 0; k < BYTES; k++) begin : g_lane
        dsi_crc_byte_lane #(.POLY(CRC_POLY)) u_lane (
            .en        (NB_W'(k) < nb_eff),
            .data_byte (in_data[k*8 +: 8]),
            .crc_in    (lane_crc[k]),
            .crc_out   (lane_crc[k+1])
        );
    end
    assign crc_fold = lane_crc[BYTES];

    // Byte counter sticks at all-ones instead of wrapping.
    assign cnt_sum  = {1'b0, byte_cnt} + (CNT_W+1)'(nb_eff);
    assign cnt_next = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];

    assign beat_acc = in_valid && in_ready;

    // Packet FSM with all outputs registered; abort overrides any state.
    always_ff @(posedge dsi_clk or negedge dsi_rst_n) begin
        if (!dsi_rst_n) begin
            state     <= IDLE;
            crc_reg   <= CRC_INIT;
            crc       <= '0;
            crc_valid <= 1'b0;
            crc_err   <= 1'b0;
            byte_cnt  <= '0;
            in_ready  <= 1'b0;
        end else if (abort) begin
            state     <= IDLE;
            crc_reg   <= CRC_INIT;
            crc_valid <= 1'b0;
            crc_err   <= 1'b0;
            byte_cnt  <= '0;
            in_ready  <= 1'b1;
        end else begin
            unique case (state)
                IDLE, ACCUM: begin
                    in_ready <= 1'b1;
                    if (beat_acc) begin
                        crc_reg  <= crc_fold;
                        byte_cnt <= cnt_next;
                        if (in_last) begin
                            state     <= DONE;
                            crc       <= crc_fold;
                            crc_err   <= chk_en && (crc_fold != rx_crc);
                            crc_valid <= 1'b1;
                            in_ready  <= 1'b0;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                DONE: begin
                    if (crc_ready) begin
                        state     <= IDLE;
                        crc_reg   <= CRC_INIT;
                        crc_valid <= 1'b0;
                        byte_cnt  <= '0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    crc_reg   <= CRC_INIT;
                    crc_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dsi_crc16_stream.sv
// Directed bench for dsi_crc16_stream: 4-byte and 1-byte beat instances.
// Latency: checks crc_valid one cycle after the last accepted beat.
// Backpressure: holds crc_ready low and checks outputs stay frozen.
module tb_dsi_crc16_stream;

    logic        dsi_clk = 1'b0;
    logic        dsi_rst_n = 1'b1;

    // 4-byte instance
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic [2:0]  in_nbytes = '0;
    logic        in_last = 1'b0;
    logic        abort = 1'b0;
    logic        chk_en = 1'b0;
    logic [15:0] rx_crc = '0;
    logic        crc_valid;
    logic        crc_ready = 1'b0;
    logic [15:0] crc;
    logic        crc_err;
    logic [15:0] byte_cnt;

    // 1-byte instance with a narrow counter to reach saturation
    logic        v1 = 1'b0;
    logic        rdy1;
    logic [7:0]  d1 = '0;
    logic [0:0]  nb1 = 1'b1;
    logic        last1 = 1'b0;
    logic        ab1 = 1'b0;
    logic        chk1 = 1'b0;
    logic [15:0] rx1 = '0;
    logic        cv1;
    logic        cr1 = 1'b0;
    logic [15:0] crc1;
    logic        err1;
    logic [3:0]  cnt1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 dsi_clk = ~dsi_clk;

    dsi_crc16_stream #(.BYTES(4), .CNT_W(16)) dut (
        .dsi_clk   (dsi_clk),
        .dsi_rst_n (dsi_rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_nbytes (in_nbytes),
        .in_last   (in_last),
        .abort     (abort),
        .chk_en    (chk_en),
        .rx_crc    (rx_crc),
        .crc_valid (crc_valid),
        .crc_ready (crc_ready),
        .crc       (crc),
        .crc_err   (crc_err),
        .byte_cnt  (byte_cnt)
    );

    dsi_crc16_stream #(.BYTES(1), .CNT_W(4)) dut1 (
        .dsi_clk   (dsi_clk),
        .dsi_rst_n (dsi_rst_n),
        .in_valid  (v1),
        .in_ready  (rdy1),
        .in_data   (d1),
        .in_nbytes (nb1),
        .in_last   (last1),
        .abort     (ab1),
        .chk_en    (chk1),
        .rx_crc    (rx1),
        .crc_valid (cv1),
        .crc_ready (cr1),
        .crc       (crc1),
        .crc_err   (err1),
        .byte_cnt  (cnt1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Present one beat on the 4-byte instance and hold it until accepted.
    task automatic send_beat(input logic [31:0] d, input logic [2:0] nb, input logic last,
                             input logic chk, input logic [15:0] rx);
        int guard;
        guard = 0;
        @(negedge dsi_clk);
        in_valid  = 1'b1;
        in_data   = d;
        in_nbytes = nb;
        in_last   = last;
        chk_en    = chk;
        rx_crc    = rx;
        while (!in_ready && guard < 50) begin
            @(negedge dsi_clk);
            guard++;
        end
        if (!in_ready) check("beat_accept_timeout", 32'(in_ready), 32'd1);
        if (last) check("valid_low_before_last", 32'(crc_valid), 32'd0);
        @(posedge dsi_clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // "123456789" as beats of 4, 4, 1.
    task automatic send_msg(input logic chk, input logic [15:0] rx);
        send_beat(32'h34333231, 3'd4, 1'b0, chk, rx);
        send_beat(32'h38373635, 3'd4, 1'b0, chk, rx);
        send_beat(32'h00000039, 3'd1, 1'b1, chk, rx);
    endtask

    // Check a pending result, optionally stall it, then consume it.
    task automatic expect_result(input string tag, input logic [15:0] crc_e, input logic err_e,
                                 input logic [15:0] cnt_e, input int hold);
        @(negedge dsi_clk);
        check({tag, "_valid"}, 32'(crc_valid), 32'd1);
        check({tag, "_crc"}, 32'(crc), 32'(crc_e));
        check({tag, "_err"}, 32'(crc_err), 32'(err_e));
        check({tag, "_cnt"}, 32'(byte_cnt), 32'(cnt_e));
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        for (int h = 0; h < hold; h++) begin
            @(negedge dsi_clk);
            check({tag, "_hold_valid"}, 32'(crc_valid), 32'd1);
            check({tag, "_hold_crc"}, 32'(crc), 32'(crc_e));
            check({tag, "_hold_err"}, 32'(crc_err), 32'(err_e));
            check({tag, "_hold_cnt"}, 32'(byte_cnt), 32'(cnt_e));
            check({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        crc_ready = 1'b1;
        @(posedge dsi_clk);
        #1;
        crc_ready = 1'b0;
        @(negedge dsi_clk);
        check({tag, "_post_valid"}, 32'(crc_valid), 32'd0);
        check({tag, "_post_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_post_cnt"}, 32'(byte_cnt), 32'd0);
        check({tag, "_post_crc_held"}, 32'(crc), 32'(crc_e));
    endtask

    // Feed a byte stream to the 1-byte instance.
    task automatic send1(input logic [7:0] b, input logic last);
        int guard;
        guard = 0;
        @(negedge dsi_clk);
        v1 = 1'b1;
        d1 = b;
        last1 = last;
        while (!rdy1 && guard < 50) begin
            @(negedge dsi_clk);
            guard++;
        end
        if (!rdy1) check("b1_accept_timeout", 32'(rdy1), 32'd1);
        if (last) check("b1_valid_low_before_last", 32'(cv1), 32'd0);
        @(posedge dsi_clk);
        #1;
        v1 = 1'b0;
        last1 = 1'b0;
    endtask

    initial begin
        // Reset state
        #3 dsi_rst_n = 1'b0;
        #1;
        check("rst_crc", 32'(crc), 32'd0);
        check("rst_valid", 32'(crc_valid), 32'd0);
        check("rst_err", 32'(crc_err), 32'd0);
        check("rst_cnt", 32'(byte_cnt), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        repeat (2) @(negedge dsi_clk);
        dsi_rst_n = 1'b1;
        @(negedge dsi_clk);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // BYTES=1: "123456789" one byte per beat
        for (int i = 0; i < 9; i++) send1(8'h31 + 8'(i), i == 8);
        @(negedge dsi_clk);
        check("b1_valid", 32'(cv1), 32'd1);
        check("b1_crc", 32'(crc1), 32'h6F91);
        check("b1_cnt", 32'(cnt1), 32'd9);
        check("b1_err", 32'(err1), 32'd0);
        cr1 = 1'b1;
        @(posedge dsi_clk);
        #1 cr1 = 1'b0;
        @(negedge dsi_clk);
        check("b1_post_valid", 32'(cv1), 32'd0);

        // BYTES=1, narrow counter: 20 bytes saturate a 4-bit count at 15
        for (int i = 0; i < 20; i++) send1(8'h31 + 8'(i % 9), i == 19);
        @(negedge dsi_clk);
        check("b1_sat_valid", 32'(cv1), 32'd1);
        check("b1_sat_cnt", 32'(cnt1), 32'd15);
        cr1 = 1'b1;
        @(posedge dsi_clk);
        #1 cr1 = 1'b0;

        // BYTES=4: 4,4,1 beats, immediate consume then stalled consume
        send_msg(1'b0, 16'h0000);
        expect_result("b4", 16'h6F91, 1'b0, 16'd9, 0);
        send_msg(1'b0, 16'h0000);
        expect_result("b4_stall", 16'h6F91, 1'b0, 16'd9, 5);

        // Empty payload
        send_beat(32'h0, 3'd0, 1'b1, 1'b0, 16'h0000);
        expect_result("empty", 16'hFFFF, 1'b0, 16'd0, 0);

        // Check mode, matching and mismatching received CRC
        send_msg(1'b1, 16'h6F91);
        expect_result("chk_ok", 16'h6F91, 1'b0, 16'd9, 0);
        send_msg(1'b1, 16'h6F90);
        expect_result("chk_bad", 16'h6F91, 1'b1, 16'd9, 1);

        // Oversized byte count is clamped to a full beat
        send_beat(32'h34333231, 3'd7, 1'b0, 1'b0, 16'h0000);
        send_beat(32'h38373635, 3'd4, 1'b0, 1'b0, 16'h0000);
        send_beat(32'h00000039, 3'd1, 1'b1, 1'b0, 16'h0000);
        expect_result("clamp", 16'h6F91, 1'b0, 16'd9, 0);

        // Abort after two beats; beat offered alongside abort is dropped
        send_beat(32'h44434241, 3'd4, 1'b0, 1'b0, 16'h0000);
        send_beat(32'h48474645, 3'd4, 1'b0, 1'b0, 16'h0000);
        @(negedge dsi_clk);
        abort     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h4C4B4A49;
        in_nbytes = 3'd4;
        in_last   = 1'b1;
        @(posedge dsi_clk);
        #1;
        abort    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge dsi_clk);
        check("abort_valid", 32'(crc_valid), 32'd0);
        check("abort_cnt", 32'(byte_cnt), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        send_msg(1'b0, 16'h0000);
        expect_result("after_abort", 16'h6F91, 1'b0, 16'd9, 0);

        // Reset in the middle of a packet
        send_beat(32'h34333231, 3'd4, 1'b0, 1'b0, 16'h0000);
        @(negedge dsi_clk);
        dsi_rst_n = 1'b0;
        #1;
        check("midrst_crc", 32'(crc), 32'd0);
        check("midrst_valid", 32'(crc_valid), 32'd0);
        check("midrst_err", 32'(crc_err), 32'd0);
        check("midrst_cnt", 32'(byte_cnt), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        @(negedge dsi_clk);
        dsi_rst_n = 1'b1;
        send_msg(1'b0, 16'h0000);
        expect_result("after_rst", 16'h6F91, 1'b0, 16'd9, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dsi_crc16_stream.md
Name: dsi_crc16_stream

Overview:
Streaming CRC-16 engine for DSI long-packet payloads, the parametrised successor of the single-shot frame CRC block. It consumes a byte-lane-parallel payload stream with a valid/ready handshake and per-beat byte count, so payloads can be any length. It outputs the DSI packet-footer CRC (poly x^16+x^12+x^5+1, reflected 0x8408, init 0xFFFF, LSB-first, no final XOR). It also checks a received CRC on the RX path. It sits between the payload packer/unpacker and the lane distributor.

Parameters:
BYTES, 4, payload bytes per beat (1..8); byte 0 = in_data[7:0] is first on the wire
CRC_INIT, 16'hFFFF, seed loaded at start of every packet
CRC_POLY, 16'h8408, reflected polynomial
CNT_W, 16, width of payload byte counter (saturating)

Ports:
dsi_clk  in  1  clock
dsi_rst_n  in  1  asynchronous active-low reset
in_valid  in  1  payload beat valid
in_ready  out  1  block can accept a beat
in_data  in  BYTES*8  payload bytes, byte 0 in LSBs
in_nbytes  in  $clog2(BYTES+1)  valid bytes in beat, contiguous from byte 0; must be BYTES except on last beat
in_last  in  1  final beat of packet
abort  in  1  discard current packet
chk_en  in  1  check mode; sampled with last beat
rx_crc  in  16  received CRC; sampled with last beat
crc_valid  out  1  result available
crc_ready  in  1  downstream consumes result
crc  out  16  computed CRC
crc_err  out  1  chk_en && (crc != rx_crc); 0 when chk_en=0
byte_cnt  out  CNT_W  bytes accumulated in packet, saturates at all-ones

Behaviour:
- Reset (async, dsi_rst_n=0): state IDLE, crc_reg=CRC_INIT, crc=0, crc_valid=0, crc_err=0, byte_cnt=0. in_ready=1 once out of reset.
- States: IDLE, ACCUM, DONE.
- IDLE: in_ready=1, crc_reg=CRC_INIT. An accepted beat (in_valid&&in_ready) folds in_nbytes bytes into crc_reg, adds them to byte_cnt, and moves to DONE if in_last, else ACCUM.
- ACCUM: in_ready=1. Each accepted beat folds its bytes. in_last moves to DONE. No beat means hold.
- Fold: bytes processed in order 0..in_nbytes-1, each LSB-first. in_nbytes=0 leaves crc_reg unchanged.
- Transition to DONE registers crc=folded value and crc_err per the check-mode compare, then sets crc_valid=1. Latency: crc_valid rises the cycle after the last beat is accepted.
- DONE: in_ready=0, crc_valid=1. crc, crc_err and byte_cnt are held stable until crc_ready=1.
- Handshake completes when crc_valid&&crc_ready: next cycle crc_valid=0, state IDLE, crc_reg=CRC_INIT, byte_cnt=0. crc is held at its last value.
- Empty payload: single beat with in_nbytes=0 and in_last=1 gives crc=16'hFFFF.
- abort (any state) has priority over everything: next cycle IDLE, crc_valid=0, crc_err=0, byte_cnt=0, crc_reg=CRC_INIT. A beat presented in the same cycle is dropped.
- A beat with in_nbytes>BYTES is clamped to BYTES.
- A non-last beat with in_nbytes<BYTES is folded as given. This is a protocol error with no flag raised.
- byte_cnt saturates at 2^CNT_W-1 and does not wrap.
- Reset asserted mid-packet: immediate return to reset values. No partial result is emitted.

Decomposition:
- Package dsi_crc_pkg holds:
  - DSI_CRC_POLY_REFL = 16'h8408 and DSI_CRC_INIT = 16'hFFFF.
  - typedef enum logic [1:0] {IDLE, ACCUM, DONE} crc_state_t.
  - function crc16_byte(crc, byte, poly): 8 reflected shift/XOR steps.
- Sub-module dsi_crc_byte_lane: combinational one-byte update with an enable. BYTES instances are chained, and lane k is bypassed when k >= in_nbytes.
- The top level holds the FSM, registers, counter and compare.

Test Plan:
- BYTES=1, ASCII "123456789" one byte/beat, last on '9', chk_en=0 -> crc=16'h6F91, crc_valid one cycle after last, byte_cnt=9, crc_err=0.
- BYTES=4, same 9 bytes as beats of 4,4,1 (in_nbytes=1 on last) -> crc=16'h6F91, byte_cnt=9. Repeat with crc_ready held low 5 cycles -> outputs stable and in_ready=0 throughout.
- Single beat in_nbytes=0, in_last=1 -> crc=16'hFFFF, byte_cnt=0.
- "123456789" with chk_en=1, rx_crc=16'h6F91 -> crc_err=0. Repeat with rx_crc=16'h6F90 -> crc_err=1.
- Assert abort after the 2nd beat of a 4-beat packet, then send "123456789" -> no crc_valid for the aborted packet, and the next result is crc=16'h6F91.
- Assert dsi_rst_n=0 mid-ACCUM, release, send "123456789" -> all outputs 0 during reset, then crc=16'h6F91.
